// File: rtl/stream_demux_pkg.sv
// Shared definitions for the registered 1:N stream demultiplexer.
//   DEF_DATA_W / DEF_N_CH / DEF_CNT_W : default parameter values
//   ch_state_e                        : per-channel buffer state (EMPTY, FULL)
//   sel_width()                       : width of the channel-select field
package stream_demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_CH   = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  // Never narrower than one bit, so a 2-channel build still has a select line.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_ch_buf.sv
// One-entry output buffer for a single demux channel.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   wr_i          : load wr_data_i on the next edge
//   wr_data_i     : payload to load
//   m_ready_i     : consumer ready for this channel
//   can_accept_o  : buffer can take a beat this cycle (empty, or draining)
//   m_valid_o     : buffer holds a beat
//   m_data_o      : buffered payload (retains last value when empty)
module demux_ch_buf
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              m_ready_i,
  output logic              can_accept_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o
);

  ch_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A write wins over a drain: a FULL buffer that is read and written in the
  // same cycle simply reloads, giving one beat per cycle with no bubble.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (wr_i) begin
      state_d = FULL;
      data_d  = wr_data_i;
    end else if (state_q == FULL && m_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign m_valid_o    = (state_q == FULL);
  assign can_accept_o = (state_q == EMPTY) || m_ready_i;
  assign m_data_o     = data_q;

endmodule

// File: rtl/stream_demux.sv
// Registered 1:N stream demultiplexer. Routes a valid/ready stream to the
// channel picked by s_sel; each channel has a one-entry buffer with its own
// back-pressure. Out-of-range selects are accepted, dropped and counted.
// Optional broadcast: define STREAM_DEMUX_BCAST_EN to let s_bcast write all
// channels at once; otherwise s_bcast is ignored.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : input handshake
//   s_data, s_sel     : input payload and destination channel
//   s_bcast           : broadcast request (optional feature)
//   m_valid, m_ready  : per-channel output handshake
//   m_data            : per-channel payload, channel k at [k*DATA_W +: DATA_W]
//   drop_cnt          : saturating count of dropped out-of-range beats
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH,
  parameter int SEL_W  = sel_width(N_CH),
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  input  logic [SEL_W-1:0]       s_sel,
  input  logic                   s_bcast,
  output logic [N_CH-1:0]        m_valid,
  input  logic [N_CH-1:0]        m_ready,
  output logic [N_CH*DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int SEL_N = 1 << SEL_W;

  logic [N_CH-1:0]  can_acc, wr;
  logic [SEL_N-1:0] can_acc_pad, sel_in_range;
  logic             bcast, sel_ok, accept, drop;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast = s_bcast;
`else
  logic unused_bcast;
  assign unused_bcast = s_bcast;
  assign bcast        = 1'b0;
`endif

  // Full-range lookup tables indexed by s_sel, so a non-power-of-2 N_CH
  // never indexes past the channel vector.
  for (genvar i = 0; i < SEL_N; i++) begin : g_range
    assign sel_in_range[i] = (i < N_CH) ? 1'b1 : 1'b0;
  end

  always_comb begin
    can_acc_pad           = '0;
    can_acc_pad[N_CH-1:0] = can_acc;
  end

  assign sel_ok = sel_in_range[s_sel];

  // Out-of-range beats are always accepted so a bad select cannot stall the
  // producer.
  assign s_ready = bcast  ? &can_acc :
                   sel_ok ? can_acc_pad[s_sel] : 1'b1;
  assign accept  = s_valid && s_ready;
  assign drop    = accept && !bcast && !sel_ok;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign wr[k] = accept && (bcast || (s_sel == SEL_W'(k)));

    demux_ch_buf #(.DATA_W(DATA_W)) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_i         (wr[k]),
      .wr_data_i    (s_data),
      .m_ready_i    (m_ready[k]),
      .can_accept_o (can_acc[k]),
      .m_valid_o    (m_valid[k]),
      .m_data_o     (m_data[k*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered 1:N stream demultiplexer; the sequential successor of the combinational 1:4 demux.
- Routes a DATA_W-bit valid/ready stream to one of N_CH output channels selected by s_sel.
- Each channel has a one-entry output buffer with independent back-pressure.
- Out-of-range selects are dropped and counted.
- Sits between a single producer and N independent consumers.

Parameters:
- DATA_W, 8: payload width in bits.
- N_CH, 4: number of output channels (2..16; need not be a power of 2).
- SEL_W, $clog2(N_CH): width of s_sel (derived; do not override).
- CNT_W, 8: width of the drop counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  DATA_W  input payload
- s_sel  in  SEL_W  destination channel index
- s_bcast  in  1  broadcast request (used only with the optional feature)
- m_valid  out  N_CH  per-channel output valid
- m_ready  in  N_CH  per-channel consumer ready
- m_data  out  N_CH*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W]
- drop_cnt  out  CNT_W  count of dropped out-of-range beats

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - m_valid = 0, m_data = 0, drop_cnt = 0.
  - All channel buffers are empty.
  - Buffered beats are discarded on a mid-operation reset; m_valid clears immediately, without waiting for a clock edge.
- Per-channel state: two states, EMPTY and FULL, held as a flag plus a DATA_W register.
- Channel k "can accept" = EMPTY, or (FULL && m_ready[k]).
- s_ready (combinational from state, s_sel, s_bcast and m_ready; no dependency on s_valid):
  - Unicast with s_sel < N_CH: can-accept of channel s_sel.
  - s_sel >= N_CH: 1, because the beat is always accepted and dropped.
- Unicast accept, s_sel = k < N_CH:
  - The buffer loads s_data on the next edge and m_valid[k] = 1.
  - Latency is exactly 1 cycle, input handshake to m_valid.
- Channel transitions:
  - FULL && m_ready[k] && no new write: goes to EMPTY.
  - FULL && m_ready[k] && new write to k in the same cycle: buffer reloads and m_valid[k] stays 1 (full throughput of 1 beat/cycle per channel).
  - FULL && !m_ready[k]: m_data[k] holds stable; s_ready = 0 for beats targeting k.
- Drop: an accepted beat with s_sel >= N_CH changes no channel state. drop_cnt increments by 1 and saturates at 2^CNT_W-1.
- Channel independence: back-pressure on channel k never blocks beats to channel j != k.
- Data hygiene: m_data of an EMPTY channel retains its last value; consumers must qualify with m_valid.

Optional Feature:
- Macro: STREAM_DEMUX_BCAST_EN.
- Defined:
  - When s_bcast = 1, s_sel is ignored.
  - s_ready = AND of can-accept over all N_CH channels.
  - On accept, every channel loads s_data and asserts m_valid the next cycle.
  - drop_cnt is unaffected by broadcast beats.
- Undefined:
  - s_bcast is ignored (port kept for a stable interface).
  - Behaviour is as unicast.

Decomposition:
- Package stream_demux_pkg holds:
  - default DATA_W, N_CH and CNT_W constants;
  - the ch_state_e enum (EMPTY, FULL);
  - a sel-width helper function.
- Sub-module demux_ch_buf is the one-entry buffer (flag, data register, load/drain logic). It is instantiated N_CH times in a generate loop.
- The top level holds routing, the s_ready mux, the broadcast AND and the drop counter.

Test Plan:
- Unicast sweep: all m_ready=1; send 0xA5 to sel 0,1,2,3 on consecutive cycles -> each m_valid[k] pulses one cycle, 1 cycle after its beat, with m_data[k]=0xA5; s_ready stays 1.
- Back-pressure: m_ready[2]=0; send 0x11, then 0x22 to sel 2 -> 0x11 holds on m_data[2]; s_ready=0 for the second beat. Beats to sel 1 are still accepted. Raising m_ready[2] delivers 0x22 the next cycle.
- Pass-through: channel 0 FULL with 0x33 and m_ready[0]=1; write 0x44 the same cycle -> m_valid[0] stays 1 and m_data[0] goes 0x33 then 0x44 with no bubble.
- Drop: N_CH=3, s_sel=3, 300 beats, CNT_W=8 -> s_ready=1 throughout, no m_valid asserted, drop_cnt=255 (saturated).
- Reset mid-operation: two channels FULL; assert rst_n=0 between clock edges -> m_valid=0 immediately and drop_cnt=0. After release, s_ready=1 for a valid sel.
- Broadcast (STREAM_DEMUX_BCAST_EN): m_ready=4'b1011 with all channels FULL; s_bcast=1, data 0x5A -> s_ready=0. Setting m_ready=4'b1111 gives accept, and all four channels show 0x5A next cycle.
